// File: rtl/seven_segment_scanner.sv
// Time-multiplexed hex driver for a bank of common-anode seven-segment digits.
// Double-buffered display word, swapped only on frame boundaries.
module seven_segment_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dpIn,
    input  logic [NUM_DIGITS-1:0]   digitEnable,
    input  logic                    leadingZeroBlank,
    input  logic                    load,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    frameStart,
    output logic                    updatePending
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] val;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   en;
    } word_t;

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    word_t                 disp, shadow, in_word;
    logic                  pend;
    logic                  slot_end, frame_end, cur_blank, zero_above;
    logic [3:0]            cur_digit;
    logic [NUM_DIGITS-1:0] lz_mask;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b100_0000;
            4'h1: hex7 = 7'b111_1001;
            4'h2: hex7 = 7'b010_0100;
            4'h3: hex7 = 7'b011_0000;
            4'h4: hex7 = 7'b001_1001;
            4'h5: hex7 = 7'b001_0010;
            4'h6: hex7 = 7'b000_0010;
            4'h7: hex7 = 7'b111_1000;
            4'h8: hex7 = 7'b000_0000;
            4'h9: hex7 = 7'b001_1000;
            4'hA: hex7 = 7'b000_1000;
            4'hB: hex7 = 7'b000_0011;
            4'hC: hex7 = 7'b010_0111;
            4'hD: hex7 = 7'b010_0001;
            4'hE: hex7 = 7'b000_0110;
            default: hex7 = 7'b000_1110;
        endcase
    endfunction

    assign in_word   = '{val: value, dp: dpIn, en: digitEnable};
    assign slot_end  = (cnt == CW'(REFRESH_DIV - 1));
    assign frame_end = slot_end && (idx == IW'(NUM_DIGITS - 1));
    assign cur_digit = disp.val[{idx, 2'b00} +: 4];

    // Walk down from the top digit; a digit is a leading zero while everything above it is zero too.
    always_comb begin
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above && (disp.val[4*k +: 4] == 4'h0);
            lz_mask[k] = zero_above;
        end
    end

    assign cur_blank = ~disp.en[idx] | (leadingZeroBlank & lz_mask[idx]);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt           <= '0;
            idx           <= '0;
            disp          <= '0;
            shadow        <= '0;
            pend          <= 1'b0;
            segments      <= 7'h7F;
            dp            <= 1'b1;
            anodes        <= '1;
            frameStart    <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;

            if (load)
                shadow <= in_word;
            // A load landing on the boundary bypasses the shadow so it is never left pending.
            if (frame_end) begin
                if (load)
                    disp <= in_word;
                else if (pend)
                    disp <= shadow;
                pend <= 1'b0;
            end else if (load) begin
                pend <= 1'b1;
            end

            segments   <= cur_blank ? 7'h7F : hex7(cur_digit);
            dp         <= cur_blank | ~disp.dp[idx];
            anodes     <= (cnt < CW'(BLANK_CYCLES)) ? '1 : ~(NUM_DIGITS'(1) << idx);
            frameStart <= (cnt == '0) && (idx == '0);
        end
    end

    assign updatePending = pend;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner: table-driven display frames
// checked through a scoreboard, plus reset, frame-sync and boundary-load sequences.
module tb_seven_segment_scanner;
    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BL = 2;
    localparam int FR = ND * RD;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  en = '0;
    logic        lzb = 1'b0;
    logic        load = 1'b0;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  anodes;
    logic        frame_start, update_pending;

    seven_segment_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .reset_n(reset_n), .value(value), .dpIn(dp_in),
        .digitEnable(en), .leadingZeroBlank(lzb), .load(load),
        .segments(segments), .dp(dp), .anodes(anodes),
        .frameStart(frame_start), .updatePending(update_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]      val;
        logic [3:0]       dpv;
        logic [3:0]       env;
        logic             lz;
        logic [3:0][6:0]  seg;
        logic [3:0]       dpo;
    } vec_t;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   errors = 0;
    int   checks = 0;
    int   ph = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (phase %0d)", name, act, exp, ph);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        ph++;
        #1;
    endtask

    task automatic run_to(input int m);
        while (ph % FR != m) tick();
    endtask

    task automatic push_vec(input vec_t v);
        for (int d = 0; d < ND; d++) sb.push_back(exp_t'{v.seg[d], v.dpo[d]});
    endtask

    task automatic do_load(input logic [15:0] val, input logic [3:0] dpv, input logic [3:0] env);
        value = val; dp_in = dpv; en = env; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Walks one full frame starting at its digit-0 slot, popping one expectation per slot.
    task automatic check_frame();
        for (int c = 0; c < FR; c++) begin
            int s, d;
            logic [3:0] an_exp;
            exp_t e;
            tick();
            s = ph % RD;
            d = (ph / RD) % ND;
            an_exp = (s < BL) ? 4'hF : ~(4'b0001 << d);
            chk("anodes", anodes, an_exp);
            chk("frameStart", frame_start, (s == 0 && d == 0));
            if (s == BL) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard: no expectation for digit %0d (phase %0d)", d, ph);
                end else begin
                    e = sb.pop_front();
                    chk("segments", segments, e.seg);
                    chk("dp", dp, e.dp);
                    chk("updatePending idle", update_pending, 0);
                end
            end
        end
    endtask

    function automatic vec_t mk(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] env,
                                input logic lz, input logic [6:0] s3, input logic [6:0] s2,
                                input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] dpo);
        vec_t r;
        r.val = v; r.dpv = dpv; r.env = env; r.lz = lz;
        r.seg = {s3, s2, s1, s0};
        r.dpo = dpo;
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = mk(16'h1A3F, 4'b0100, 4'hF, 1'b0, 7'h79, 7'h08, 7'h30, 7'h0E, 4'b1011);
        tbl[1] = mk(16'h0050, 4'h0,    4'hF, 1'b1, 7'h7F, 7'h7F, 7'h12, 7'h40, 4'hF);
        tbl[2] = mk(16'h0000, 4'h0,    4'hF, 1'b1, 7'h7F, 7'h7F, 7'h7F, 7'h40, 4'hF);
        tbl[3] = mk(16'h8888, 4'hF,    4'hF, 1'b0, 7'h00, 7'h00, 7'h00, 7'h00, 4'h0);
        tbl[4] = mk(16'h4B2C, 4'hF,    4'b1010, 1'b0, 7'h19, 7'h7F, 7'h24, 7'h7F, 4'b0101);
        tbl[5] = mk(16'h0D06, 4'b0001, 4'hF, 1'b1, 7'h7F, 7'h21, 7'h40, 7'h02, 4'b1110);
        tbl[6] = mk(16'h9E75, 4'h0,    4'hF, 1'b0, 7'h18, 7'h06, 7'h78, 7'h12, 4'hF);
        tbl[7] = mk(16'hCB00, 4'h0,    4'hF, 1'b1, 7'h27, 7'h03, 7'h40, 7'h40, 4'hF);

        // Reset state, then first frame after release.
        repeat (3) tick();
        chk("reset segments", segments, 7'h7F);
        chk("reset dp", dp, 1);
        chk("reset anodes", anodes, 4'hF);
        chk("reset frameStart", frame_start, 0);
        chk("reset updatePending", update_pending, 0);
        reset_n = 1'b1; ph = -1;
        tick();
        chk("post-reset anodes blank", anodes, 4'hF);
        chk("post-reset frameStart", frame_start, 1);
        tick();
        chk("post-reset frameStart pulse", frame_start, 0);
        tick();
        chk("first anode", anodes, 4'hE);
        chk("first segments blank", segments, 7'h7F);
        chk("first dp", dp, 1);

        // Table-driven frames: load mid-frame, shown from the next frame.
        for (int i = 0; i < 8; i++) begin
            run_to(8);
            lzb = tbl[i].lz;
            push_vec(tbl[i]);
            do_load(tbl[i].val, tbl[i].dpv, tbl[i].env);
            chk("pending after load", update_pending, 1);
            run_to(FR - 1);
            chk("pending cleared at boundary", update_pending, 0);
            check_frame();
        end

        // Two loads in one frame: only the last reaches the display.
        lzb = 1'b0;
        run_to(8);
        do_load(16'h0000, 4'h0, 4'hF);
        chk("pending first load", update_pending, 1);
        run_to(16);
        push_vec(mk(16'h8888, 4'h0, 4'hF, 1'b0, 7'h00, 7'h00, 7'h00, 7'h00, 4'hF));
        do_load(16'h8888, 4'h0, 4'hF);
        run_to(FR - 2);
        chk("pending held to boundary", update_pending, 1);
        tick();
        chk("pending cleared after overwrite", update_pending, 0);
        check_frame();

        // Load exactly on the boundary cycle.
        run_to(FR - 2);
        push_vec(mk(16'h2345, 4'hF, 4'hF, 1'b0, 7'h24, 7'h30, 7'h19, 7'h12, 4'h0));
        value = 16'h2345; dp_in = 4'hF; en = 4'hF; load = 1'b1;
        tick();
        load = 1'b0;
        chk("boundary load no pending", update_pending, 0);
        check_frame();

        // Reset in the digit-2 slot with an update pending.
        run_to(8);
        do_load(16'h1234, 4'h0, 4'hF);
        chk("pending before reset", update_pending, 1);
        run_to(17);
        reset_n = 1'b0;
        tick();
        chk("mid reset segments", segments, 7'h7F);
        chk("mid reset dp", dp, 1);
        chk("mid reset anodes", anodes, 4'hF);
        chk("mid reset frameStart", frame_start, 0);
        chk("mid reset updatePending", update_pending, 0);
        repeat (2) tick();
        reset_n = 1'b1; ph = -1;
        tick();
        chk("after reset pending", update_pending, 0);
        chk("after reset frameStart", frame_start, 1);
        tick(); tick();
        chk("after reset anode", anodes, 4'hE);
        chk("after reset segments blank", segments, 7'h7F);
        chk("after reset pending held", update_pending, 0);

        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: %0d expectations left unconsumed", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
